// File: rtl/alu_pkg.sv
// Purpose: shared constants for the down-sampler ALU: operand width, op codes,
//          FSM state encodings and the divide-by-zero result.
// Ports:   none (package).
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // All-ones; truncated to the operand width at the point of use.
  localparam logic [63:0] DIV_ZERO_RES = '1;

  // MUL and DIV take the iterative path; everything else is single-cycle.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Purpose: iterative MUL (shift-add) and DIV (restoring shift-subtract) datapath.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          i_load        - latch operands and clear the accumulator
//          i_step        - perform one iteration
//          i_is_div      - operation select, sampled with i_load
//          i_a, i_b      - operands, sampled with i_load
//          o_result      - product low half or quotient (valid after WIDTH steps)
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  // r_acc: product accumulator (MUL) or partial remainder (DIV)
  // r_opa: shifted multiplicand (MUL) or dividend/quotient shift register (DIV)
  // r_opb: shifted multiplier (MUL) or divisor (DIV)
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_is_div;
  logic             r_b_zero;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_sub;
  logic             w_fits;
  logic [WIDTH-1:0] w_mul_acc;

  // One step of each algorithm; the remainder needs one extra bit before the compare.
  always_comb begin
    w_rem_sh  = {r_acc, r_opa[WIDTH-1]};
    w_rem_sub = w_rem_sh - {1'b0, r_opb};
    w_fits    = (w_rem_sh >= {1'b0, r_opb});
    w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_opa    <= i_a;
      r_opb    <= i_b;
      r_is_div <= i_is_div;
      r_b_zero <= (i_b == '0);
    end else if (i_step) begin
      if (r_is_div) begin
        // Remainder after a successful subtract is below the divisor, so it fits WIDTH bits.
        r_acc <= w_fits ? WIDTH'(w_rem_sub) : WIDTH'(w_rem_sh);
        r_opa <= {r_opa[WIDTH-2:0], w_fits};
      end else begin
        r_acc <= w_mul_acc;
        r_opa <= {r_opa[WIDTH-2:0], 1'b0};
        r_opb <= {1'b0, r_opb[WIDTH-1:1]};
      end
    end
  end

  assign o_result = r_is_div ? (r_b_zero ? WIDTH'(DIV_ZERO_RES) : r_opa) : r_acc;

endmodule

// File: rtl/alu_unit.sv
// Purpose: sequential ALU feeding the register file c_in bus; single-cycle
//          PASS/ADD/SUB/INC/DEC/SHR and iterative MUL/DIV.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          start, op     - launch request and op code (sampled only in IDLE)
//          a_in, b_in    - operands, sampled with start
//          busy          - an operation is outstanding (until done drops)
//          done          - one-cycle pulse, destination register write enable
//          c_out, z_flag - result and zero flag, updated only with done
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c_out,
  output logic             z_flag
);

  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quick;
  logic             r_iter;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_c;
  logic             r_z;

  logic [1:0]       w_state_nxt;
  logic             w_accept;
  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic [WIDTH-1:0] w_quick;
  logic [WIDTH-1:0] w_core_res;
  logic [WIDTH-1:0] w_final;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (is_iter_op(op)) begin
            w_load      = 1'b1;
            w_state_nxt = ST_EXEC;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        w_step = 1'b1;
        if (r_cnt == '0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_finish    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle results
  always_comb begin
    w_quick = '0;
    case (op)
      OP_PASS: w_quick = a_in;
      OP_ADD:  w_quick = a_in + b_in;
      OP_SUB:  w_quick = a_in - b_in;
      OP_INC:  w_quick = a_in + WIDTH'(1);
      OP_DEC:  w_quick = a_in - WIDTH'(1);
      OP_SHR:  w_quick = {1'b0, a_in[WIDTH-1:1]};
      default: w_quick = '0;
    endcase
  end

  assign w_final = r_iter ? w_core_res : r_quick;

  // Counter, captured result and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_quick <= '0;
      r_iter  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_c     <= '0;
      r_z     <= 1'b0;
    end else begin
      r_done <= w_finish;
      // busy stays up through the done cycle, not just while the FSM is away from IDLE
      r_busy <= (w_state_nxt != ST_IDLE) || w_finish;
      if (w_accept) begin
        r_quick <= w_quick;
        r_iter  <= is_iter_op(op);
      end
      if (w_load)                      r_cnt <= CNT_W'(ITER - 1);
      else if (w_step && r_cnt != '0)  r_cnt <= r_cnt - CNT_W'(1);
      if (w_finish) begin
        r_c <= w_final;
        r_z <= (w_final == '0);
      end
    end
  end

  alu_iter_core #(.WIDTH(WIDTH)) u_iter_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (op == OP_DIV),
    .i_a      (a_in),
    .i_b      (b_in),
    .o_result (w_core_res)
  );

  assign busy   = r_busy;
  assign done   = r_done;
  assign c_out  = r_c;
  assign z_flag = r_z;

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] c_out;
  logic        z_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .c_out  (c_out),
    .z_flag (z_flag)
  );

  // Reference: plain unsigned arithmetic, wrapped to 16 bits.
  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r;
    case (o)
      3'd0: r = ua;
      3'd1: r = ua + ub;
      3'd2: r = ua - ub;
      3'd3: r = ua + 1;
      3'd4: r = ua - 1;
      3'd5: r = ua / 2;
      3'd6: r = ua * ub;
      default: r = (ub == 0) ? 32'hFFFF : ua / ub;
    endcase
    return 16'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge. noise: fire ignored starts during EXEC.
  // b2b: return at the done cycle so the next start lands as early as allowed.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input bit noise, input bit b2b);
    logic [15:0] exp_c;
    logic [15:0] prev_c;
    int          lat;
    int          n;
    bit          busy_ok;
    bit          hold_ok;
    exp_c   = model(o, a, b);
    lat     = (o >= 3'd6) ? 17 : 1;
    prev_c  = c_out;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (c_out !== prev_c) hold_ok = 1'b0;
      if (noise && n >= 2 && n <= 10) begin
        start = n[0];
        op    = 3'd1;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, " c_out"}, {16'd0, c_out}, {16'd0, exp_c});
    check({tag, " z_flag"}, {31'd0, z_flag}, {31'd0, exp_c == 16'd0});
    if (!b2b) begin
      check({tag, " busy@done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      check({tag, " done pulse"}, {31'd0, done}, 32'd0);
      check({tag, " idle"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; start = 1'b0; op = 3'd0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst c_out", {16'd0, c_out}, 32'd0);
    check("rst z", {31'd0, z_flag}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add", 3'd1, 16'h0003, 16'h0005, 1'b0, 1'b0);
    run_op("sub", 3'd2, 16'h0002, 16'h0005, 1'b0, 1'b0);
    run_op("dec", 3'd4, 16'h0001, 16'h0000, 1'b0, 1'b0);
    run_op("pass", 3'd0, 16'hA5C3, 16'h1111, 1'b0, 1'b0);
    run_op("inc wrap", 3'd3, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    run_op("shr", 3'd5, 16'h8001, 16'h0000, 1'b0, 1'b0);
    run_op("mul", 3'd6, 16'h0123, 16'h0045, 1'b0, 1'b0);
    run_op("mul wrap", 3'd6, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
    run_op("div avg", 3'd7, 16'h03FC, 16'h0004, 1'b0, 1'b0);
    run_op("div0", 3'd7, 16'h1234, 16'h0000, 1'b0, 1'b0);
    run_op("mul noise", 3'd6, 16'h00FF, 16'h0101, 1'b1, 1'b0);

    // Back-to-back single-cycle ops, each started in the cycle done is visible
    run_op("b2b0", 3'd1, 16'h1000, 16'h0234, 1'b0, 1'b1);
    run_op("b2b1", 3'd2, 16'h0000, 16'h0001, 1'b0, 1'b1);
    run_op("b2b2", 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Random ops against the model
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  ro;
      logic [15:0] ra;
      logic [15:0] rb;
      ro = 3'($urandom_range(7, 0));
      ra = 16'($urandom);
      rb = ($urandom_range(7, 0) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(15, 0));
      run_op("rand", ro, ra, rb, 1'b0, ($urandom_range(1, 0) == 1));
    end
    @(negedge clk);

    // Reset in the middle of a DIV: aborted, no done, outputs cleared
    run_op("pre mul", 3'd6, 16'h0033, 16'h0011, 1'b0, 1'b0);
    start = 1'b1; op = 3'd7; a_in = 16'hFFF0; b_in = 16'h0007;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort c_out", {16'd0, c_out}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort z", {31'd0, z_flag}, 32'd0);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    check("abort quiet", {31'd0, quiet}, 32'd1);
    run_op("post rst add", 3'd1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
